// File: rtl/mor1kx_pht_pkg.sv
// Shared types and helpers for the pattern-history-table controller.
package mor1kx_pht_pkg;

    // 2-bit saturating counter encodings
    typedef enum logic [1:0] {
        CNT_SNT = 2'd0,
        CNT_WNT = 2'd1,
        CNT_WT  = 2'd2,
        CNT_ST  = 2'd3
    } pht_counter_e;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } pht_state_e;

    // Move a counter one step toward the resolved outcome, saturating at the ends
    function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
        logic [1:0] res;
        res = cnt;
        if (taken) begin
            if (cnt != 2'(CNT_ST)) res = cnt + 2'd1;
        end else begin
            if (cnt != 2'(CNT_SNT)) res = cnt - 2'd1;
        end
        return res;
    endfunction

    // Static prediction used while the table is not valid: backward branches taken
    function automatic logic [1:0] fallback_counter(input logic bwd);
        return bwd ? 2'(CNT_WT) : 2'(CNT_WNT);
    endfunction

endpackage

// File: rtl/mor1kx_pht_update_fifo.sv
// Circular FIFO of pending counter updates with a newest-match index search.
module mor1kx_pht_update_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned IW    = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          push,
    input  logic [IW-1:0] push_index,
    input  logic [1:0]    push_counter,
    input  logic          pop,
    output logic [IW-1:0] head_index,
    output logic [1:0]    head_counter,
    output logic          full,
    output logic          empty,
    input  logic [IW-1:0] match_index,
    output logic          match_hit,
    output logic [1:0]    match_counter
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [IW-1:0] idx_q [DEPTH];
    logic [1:0]    cnt_q [DEPTH];
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] wr_ptr_q;
    logic [CW-1:0] count_q;
    logic [PW:0]   pos;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    // Entry storage; contents are only meaningful below count_q
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            idx_q[wr_ptr_q] <= push_index;
            cnt_q[wr_ptr_q] <= push_counter;
        end
    end

    assign head_index   = idx_q[rd_ptr_q];
    assign head_counter = cnt_q[rd_ptr_q];
    assign full         = (count_q == CW'(DEPTH));
    assign empty        = (count_q == '0);

    // Walk oldest to newest so the last hit found is the newest one
    always_comb begin
        match_hit     = 1'b0;
        match_counter = '0;
        pos           = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            pos = (PW + 1)'(rd_ptr_q) + (PW + 1)'(i);
            if (pos >= (PW + 1)'(DEPTH)) pos = pos - (PW + 1)'(DEPTH);
            if ((CW'(i) < count_q) && (idx_q[PW'(pos)] == match_index)) begin
                match_hit     = 1'b1;
                match_counter = cnt_q[PW'(pos)];
            end
        end
    end

endmodule

// File: rtl/mor1kx_pht_ctrl.sv
// PHT controller: init sequencing, lookup/update port arbitration and forwarding.
module mor1kx_pht_ctrl
    import mor1kx_pht_pkg::*;
#(
    parameter int unsigned INDEX_WIDTH  = 6,
    parameter int unsigned UPDQ_DEPTH   = 2,
    parameter logic [1:0]  COUNTER_INIT = 2'b01
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush_i,
    output logic                   busy_o,
    input  logic                   lookup_valid_i,
    input  logic [INDEX_WIDTH-1:0] lookup_index_i,
    input  logic                   lookup_bwd_i,
    output logic                   lookup_stall_o,
    output logic                   pred_valid_o,
    output logic                   pred_flag_o,
    output logic [1:0]             pred_counter_o,
    input  logic                   upd_valid_i,
    input  logic [INDEX_WIDTH-1:0] upd_index_i,
    input  logic [1:0]             upd_counter_i,
    input  logic                   upd_flag_i,
    output logic                   ram_en_o,
    output logic                   ram_we_o,
    output logic [INDEX_WIDTH-1:0] ram_addr_o,
    output logic [1:0]             ram_wdata_o,
    input  logic [1:0]             ram_rdata_i
);

    localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = '1;

    pht_state_e             state_q, state_d;
    logic [INDEX_WIDTH-1:0] init_ptr_q, init_ptr_d;

    logic                   fifo_push, fifo_pop, fifo_clear;
    logic                   fifo_full, fifo_empty;
    logic [INDEX_WIDTH-1:0] head_index;
    logic [1:0]             head_counter, upd_next;
    logic                   fifo_hit;
    logic [1:0]             fifo_hit_counter;

    logic                   look_acc, look_fb, inc_hit, fwd_hit;
    logic [1:0]             fwd_counter;

    logic                   pred_valid_q, pred_fb_q, pred_bwd_q, pred_hit_q;
    logic [1:0]             pred_hit_counter_q;

    assign upd_next = sat_update(upd_counter_i, upd_flag_i);

    mor1kx_pht_update_fifo #(
        .DEPTH (UPDQ_DEPTH),
        .IW    (INDEX_WIDTH)
    ) u_updq (
        .clk           (clk),
        .rst_n         (rst_n),
        .clear         (fifo_clear),
        .push          (fifo_push),
        .push_index    (upd_index_i),
        .push_counter  (upd_next),
        .pop           (fifo_pop),
        .head_index    (head_index),
        .head_counter  (head_counter),
        .full          (fifo_full),
        .empty         (fifo_empty),
        .match_index   (lookup_index_i),
        .match_hit     (fifo_hit),
        .match_counter (fifo_hit_counter)
    );

    // Same-cycle incoming update is newer than anything already queued
    assign inc_hit     = fifo_push && (upd_index_i == lookup_index_i);
    assign fwd_hit     = inc_hit || fifo_hit;
    assign fwd_counter = inc_hit ? upd_next : fifo_hit_counter;

    // State and init pointer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            init_ptr_q <= '0;
        end else begin
            state_q    <= state_d;
            init_ptr_q <= init_ptr_d;
        end
    end

    // Next state and RAM port arbitration
    always_comb begin
        state_d        = state_q;
        init_ptr_d     = init_ptr_q;
        ram_en_o       = 1'b0;
        ram_we_o       = 1'b0;
        ram_addr_o     = '0;
        ram_wdata_o    = '0;
        lookup_stall_o = 1'b0;
        fifo_push      = 1'b0;
        fifo_pop       = 1'b0;
        fifo_clear     = 1'b0;
        look_acc       = 1'b0;
        look_fb        = 1'b0;
        if (flush_i) begin
            state_d    = ST_INIT;
            init_ptr_d = '0;
            fifo_clear = 1'b1;
            look_acc   = lookup_valid_i;
            look_fb    = 1'b1;
        end else if (state_q == ST_INIT) begin
            ram_en_o    = 1'b1;
            ram_we_o    = 1'b1;
            ram_addr_o  = init_ptr_q;
            ram_wdata_o = COUNTER_INIT;
            init_ptr_d  = init_ptr_q + INDEX_WIDTH'(1);
            if (init_ptr_q == LAST_INDEX) state_d = ST_RUN;
            look_acc    = lookup_valid_i;
            look_fb     = 1'b1;
        end else begin
            fifo_push = upd_valid_i;
            if (fifo_full) begin
                fifo_pop       = 1'b1;
                ram_en_o       = 1'b1;
                ram_we_o       = 1'b1;
                ram_addr_o     = head_index;
                ram_wdata_o    = head_counter;
                lookup_stall_o = lookup_valid_i;
            end else if (lookup_valid_i) begin
                ram_en_o   = 1'b1;
                ram_addr_o = lookup_index_i;
                look_acc   = 1'b1;
            end else if (!fifo_empty) begin
                fifo_pop    = 1'b1;
                ram_en_o    = 1'b1;
                ram_we_o    = 1'b1;
                ram_addr_o  = head_index;
                ram_wdata_o = head_counter;
            end
        end
    end

    // Prediction pipeline stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_valid_q       <= 1'b0;
            pred_fb_q          <= 1'b0;
            pred_bwd_q         <= 1'b0;
            pred_hit_q         <= 1'b0;
            pred_hit_counter_q <= '0;
        end else begin
            pred_valid_q       <= look_acc;
            pred_fb_q          <= look_fb;
            pred_bwd_q         <= lookup_bwd_i;
            pred_hit_q         <= look_acc && !look_fb && fwd_hit;
            pred_hit_counter_q <= fwd_counter;
        end
    end

    // Prediction result: fallback, forwarded value, or RAM read data
    always_comb begin
        pred_counter_o = '0;
        if (pred_valid_q) begin
            if (pred_fb_q)       pred_counter_o = fallback_counter(pred_bwd_q);
            else if (pred_hit_q) pred_counter_o = pred_hit_counter_q;
            else                 pred_counter_o = ram_rdata_i;
        end
    end

    assign pred_valid_o = pred_valid_q;
    assign pred_flag_o  = pred_counter_o[1];
    assign busy_o       = (state_q == ST_INIT);

endmodule
